ifu_prefetch: RTL
=================

// Module: ifu_prefetch
// PURPOSE
//  Instruction-fetch front end that sits directly upstream of the core decode path (expander/decoder).
//  Issues in-order word fetches to instruction memory over a valid/ready request channel.
//  Buffers returned words with their PC in a small FIFO and hands them to the core over a valid/ready channel.
//  Redirects from branch/jump resolution flush the buffer and discard in-flight responses.
// PARAMETERS
//  AW        32  address width (bits)
//  DW        32  instruction width (bits)
//  DEPTH     4   FIFO entries, also max outstanding requests; power of two, >=2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  redirect       in   1   flush and restart fetch at redirect_pc
//  redirect_pc    in   AW  new fetch address, word aligned
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request
//  imem_req_addr  out  AW  fetch address
//  imem_rsp_valid in   1   response valid; in request order, no backpressure
//  imem_rsp_data  in   DW  fetched word
//  instr_valid    out  1   FIFO head valid
//  instr_ready    in   1   core consumes head
//  instr          out  DW  head instruction
//  instr_pc       out  AW  head PC
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC; FIFO empty; outstanding=0; state=BOOT; imem_req_valid=0, instr_valid=0; instr/instr_pc=0.
//  - FSM: BOOT -> RUN after 1 cycle. RUN -> DRAIN on redirect when outstanding-after-cycle>0, else stays RUN.
//    DRAIN -> RUN in the cycle the last stale response returns.
//  - imem_req_valid = (state==RUN) && !redirect && (count+outstanding < DEPTH); imem_req_addr = fetch_pc.
//  - Accept (req_valid&&ready): fetch_pc += 4 (wraps mod 2^AW); outstanding++.
//  - Response in RUN: push {rsp_data, pc of oldest in-flight req}; outstanding--. The credit rule guarantees no overflow.
//  - Response in DRAIN or in redirect cycle: discarded; outstanding--.
//  - instr_valid = !empty; pop on instr_valid&&instr_ready. Push and pop in the same cycle are allowed, count unchanged.
//  - Push into empty FIFO: visible at instr_valid the next cycle (1-cycle rsp->instr latency).
//  - Redirect (priority over all): FIFO cleared, pop ignored, fetch_pc<=redirect_pc, no request accepted this cycle.
//    A redirect in DRAIN updates fetch_pc again; state stays DRAIN.
//  - Minimum latency redirect -> first request: 1 cycle if nothing is in flight.
//  - redirect_pc[1:0] is ignored (forced to 0).
//  - Response with outstanding==0 is illegal: assertion in sim, ignored in RTL.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: extra outputs perf_fetch_cnt[31:0] (accepted requests) and perf_stall_cnt[31:0]
//    (cycles with instr_valid=0 in RUN/DRAIN). Both reset to 0 and wrap at 2^32.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset, ready=1 always, rsp 1 cycle after accept -> addrs 0,4,8,...; instr_pc matches; first instr_valid in cycle 3.
//  2 instr_ready=0, memory always ready -> exactly DEPTH(4) requests accepted, then req_valid=0; FIFO full, no loss.
//  3 2 requests in flight, redirect to 0x100 -> both responses dropped, state DRAIN; next request addr 0x100 after last drop.
//  4 Redirect with push+pop same cycle -> FIFO empty next cycle, instr_valid=0, no stale instr ever presented.
//  5 Redirect to 0xFFFFFFFC -> fetch addrs 0xFFFFFFFC then 0x00000000 (wrap).
//  6 rst asserted mid-stream with 3 in flight -> outputs go to reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction prefetch front end: in-order word fetch with credit-limited issue and a PC-tagged FIFO.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_prefetch #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt,
`endif
  output logic [AW-1:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;

  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic          req_accept;
  logic          rsp_legal;
  logic          rsp_push;
  logic          do_pop;
  logic [CW:0]   credit_sum;
  logic [AW-1:0] rsp_pc;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // In-flight requests are always the contiguous words just below fetch_pc,
  // so the oldest one's PC is recovered arithmetically instead of being queued.
  assign rsp_pc = fetch_pc_reg - (AW'(outstanding_reg) << 2);

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;

    credit_sum       = {1'b0, count_reg} + {1'b0, outstanding_reg};
    imem_req_valid   = (state_reg == RUN) && !redirect && (credit_sum < (CW+1)'(DEPTH));
    imem_req_addr    = fetch_pc_reg;
    req_accept       = imem_req_valid && imem_req_ready;
    rsp_legal        = imem_rsp_valid && (outstanding_reg != '0);
    rsp_push         = rsp_legal && (state_reg == RUN) && !redirect;
    do_pop           = instr_valid && instr_ready && !redirect;
    outstanding_next = outstanding_reg + CW'(req_accept) - CW'(rsp_legal);

    if (redirect) begin
      fetch_pc_next = {redirect_pc[AW-1:2], 2'b00};
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (req_accept) fetch_pc_next = fetch_pc_reg + AW'(4);
      if (rsp_push)   wr_ptr_next   = wr_ptr_reg + PW'(1);
      if (do_pop)     rd_ptr_next   = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(rsp_push) - CW'(do_pop);
    end

    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (redirect && (outstanding_next != '0)) state_next = DRAIN;
      DRAIN:   if (outstanding_next == '0) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // Storage carries no reset; the count gates everything that reads it.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      data_mem[wr_ptr_reg] <= imem_rsp_data;
      pc_mem[wr_ptr_reg]   <= rsp_pc;
    end
  end

  assign instr_valid = (count_reg != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_reg] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : '0;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!instr_valid && (state_reg != BOOT)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  // A response with nothing in flight is a memory-side protocol error.
  a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_reg != '0));

endmodule
